// File: rtl/ifu_imem_if.sv
// Fetch-side read handshake between the instruction-fetch unit (master) and
// the instruction memory responder (slave).
interface ifu_imem_if;
  logic        Send_Signal;
  logic [63:0] AXI4_ADDR;
  logic        AXI_READ_DONE;
  logic [63:0] AXI4_DATA;
  logic        resp_err;

  modport master (output Send_Signal, AXI4_ADDR,
                  input  AXI_READ_DONE, AXI4_DATA, resp_err);
  modport slave  (input  Send_Signal, AXI4_ADDR,
                  output AXI_READ_DONE, AXI4_DATA, resp_err);
endinterface

// File: rtl/ifu_imem_responder.sv
// Instruction memory responder: level-held fetch request, fixed (or, with
// RAND_LATENCY_EN defined, LFSR-jittered) latency, one-cycle done strobe.
module ifu_imem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          LATENCY   = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  ifu_imem_if.slave                bus,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [63:0]              ld_data,
  output logic                     busy
);
  localparam int IW = $clog2(DEPTH);

  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

  state_t         state;
  logic [8:0]     cnt;
  logic [IW-1:0]  idx;
  logic           hit;
  logic [63:0]    mem [DEPTH];

  logic [63:0]    off;
  logic           in_range;
  logic [8:0]     lat_load;

  // Offset wraps mod 2^64, so addresses below BASE_ADDR land far out of range.
  assign off      = bus.AXI4_ADDR - BASE_ADDR;
  assign in_range = off < (64'(DEPTH) << 3);
  assign busy     = (state != IDLE);

`ifdef RAND_LATENCY_EN
  logic [7:0] lfsr;
  assign lat_load = 9'(LATENCY) + {6'd0, lfsr[2:0]};
`else
  assign lat_load = 9'(LATENCY);
`endif

  // Backdoor port is never gated by reset or state.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      idx               <= '0;
      hit               <= 1'b0;
      bus.AXI_READ_DONE <= 1'b0;
      bus.AXI4_DATA     <= '0;
      bus.resp_err      <= 1'b0;
`ifdef RAND_LATENCY_EN
      lfsr              <= LFSR_SEED;
`endif
    end else begin
      bus.AXI_READ_DONE <= 1'b0;
      case (state)
        IDLE: if (bus.Send_Signal) begin
          idx   <= off[IW+2:3];
          hit   <= in_range;
          cnt   <= lat_load;
          state <= (lat_load == 9'd0) ? RESP : WAIT;
`ifdef RAND_LATENCY_EN
          lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
        end
        WAIT: begin
          cnt <= cnt - 9'd1;
          if (!bus.Send_Signal)  state <= IDLE;
          else if (cnt == 9'd1)  state <= RESP;
        end
        RESP: begin
          // Same-edge backdoor write to idx is not visible: old word is returned.
          bus.AXI_READ_DONE <= 1'b1;
          bus.AXI4_DATA     <= hit ? mem[idx] : 64'h0;
          bus.resp_err      <= !hit;
          state             <= DRAIN;
        end
        DRAIN: if (!bus.Send_Signal) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_imem_responder.sv
// Three responders (LATENCY 2, 0, 4) share one request stream; each is
// compared every cycle against a timestamp-based transaction model.
module tb_ifu_imem_responder;
  localparam int          DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          NI    = 3;
`ifdef RAND_LATENCY_EN
  localparam int RX = 5;
`else
  localparam int RX = 0;
`endif

  logic          clk = 0, rst = 1, req = 0, ld_en = 0;
  logic [63:0]   addr = 0, ld_data = 0;
  logic [9:0]    ld_idx = 0;
  logic [NI-1:0] busy_v;
  int            cyc = 0, npass = 0, ntot = 0;
  bit            chk_on = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int L = (gi == 0) ? 2 : (gi == 1) ? 0 : 4;
    ifu_imem_if bus();
    assign bus.Send_Signal = req;
    assign bus.AXI4_ADDR   = addr;

    ifu_imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(L), .LFSR_SEED(8'hA5)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .busy(busy_v[gi]));

    // Model: a request accepted at edge acc responds at edge acc+Le+1, unless
    // the request is seen low at an edge strictly between the two.
    logic [63:0] sh [DEPTH];
    bit          m_busy = 0, m_done = 0, m_err = 0;
    logic [63:0] m_data = 0, p_addr = 0, off = 0;
    logic [7:0]  m_lfsr = 8'hA5;
    int          acc = 0, due = 0, le = 0, ndone = 0, lat = -1;

    always @(posedge clk) begin
      if (rst) begin
        m_busy = 0; m_done = 0; m_data = 0; m_err = 0; m_lfsr = 8'hA5;
      end else begin
        m_done = 0;
        if (!m_busy) begin
          if (req) begin
            m_busy = 1; acc = cyc; p_addr = addr; le = L;
`ifdef RAND_LATENCY_EN
            le = L + int'(m_lfsr[2:0]);
            m_lfsr = lfsr_step(m_lfsr);
`endif
            due = cyc + le + 1;
          end
        end else if (cyc < due) begin
          if (!req) m_busy = 0;
        end else if (cyc == due) begin
          m_done = 1;
          off = p_addr - BASE;
          if (off < 64'(DEPTH * 8)) begin m_data = sh[off[12:3]]; m_err = 0; end
          else begin m_data = 0; m_err = 1; end
        end else if (!req) m_busy = 0;
      end
      if (ld_en) sh[ld_idx] = ld_data;
    end

    always @(negedge clk) if (chk_on) begin
      chk($sformatf("done%0d", gi), 64'(bus.AXI_READ_DONE), 64'(m_done));
      chk($sformatf("data%0d", gi), bus.AXI4_DATA, m_data);
      chk($sformatf("err%0d", gi),  64'(bus.resp_err), 64'(m_err));
      chk($sformatf("busy%0d", gi), 64'(busy_v[gi]), 64'(m_busy));
      if (bus.AXI_READ_DONE) begin ndone++; lat = cyc - acc - 2; end
    end
  end

  task automatic load(input int i, input logic [63:0] d);
    @(posedge clk); #1 ld_en = 1; ld_idx = 10'(i); ld_data = d;
    @(posedge clk); #1 ld_en = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_v != 0 && n < 40) begin @(negedge clk); n++; end
    if (busy_v != 0) chk("idle_timeout", 64'(busy_v), 64'd0);
  endtask

  task automatic fetch(input logic [63:0] a, input int hold, input bit rnd_ld);
    @(posedge clk); #1 req = 1; addr = a;
    for (int k = 0; k < hold; k++) begin
      if (rnd_ld) begin
        ld_en = ($urandom_range(0, 2) == 0);
        ld_idx = 10'($urandom_range(0, 7));
        ld_data = {$urandom, $urandom};
      end
      @(posedge clk); #1;
    end
    ld_en = 0; req = 0;
    wait_idle();
  endtask

  int b0, b1, b2;
  logic [63:0] ra;

  initial begin
    load(0, 64'h0000_0013_0000_0093);  // lands while rst is held
    @(negedge clk);
    chk("rst_busy", 64'(busy_v), 64'd0);
    chk("rst_done", 64'(g_inst[0].bus.AXI_READ_DONE), 64'd0);
    chk("rst_data", g_inst[0].bus.AXI4_DATA, 64'd0);
    chk("rst_err",  64'(g_inst[0].bus.resp_err), 64'd0);
    @(posedge clk); #1 rst = 0; chk_on = 1;
    load(1, 64'hDEAD_BEEF_CAFE_F00D);
    load(2, 64'h1111_2222_3333_4444);
    for (int i = 3; i < 8; i++) load(i, {$urandom, $urandom});

    b0 = g_inst[0].ndone; b1 = g_inst[1].ndone; b2 = g_inst[2].ndone;
    fetch(BASE, 16, 0);
    chk("t1_data", g_inst[0].bus.AXI4_DATA, 64'h0000_0013_0000_0093);
    chk("t1_err", 64'(g_inst[0].bus.resp_err), 64'd0);
    chk("t1_one_done", 64'(g_inst[0].ndone - b0), 64'd1);
    chk("t1_lat0", 64'(g_inst[0].lat), 64'(2 + RX));
    chk("t1_lat1", 64'(g_inst[1].lat), 64'(0 + RX));
    chk("t1_lat2", 64'(g_inst[2].lat), 64'(4 + RX));

    fetch(BASE + 64'd4, 16, 0);
    chk("t2_sub_dw", g_inst[0].bus.AXI4_DATA, 64'h0000_0013_0000_0093);
    fetch(BASE + 64'h2000, 16, 0);
    chk("t3_oor_data", g_inst[0].bus.AXI4_DATA, 64'd0);
    chk("t3_oor_err", 64'(g_inst[0].bus.resp_err), 64'd1);
    fetch(64'h0000_0000_7FFF_FFF8, 16, 0);
    chk("t4_below_err", 64'(g_inst[0].bus.resp_err), 64'd1);

    b1 = g_inst[1].ndone;
    fetch(BASE + 64'd8, 16, 0);
    chk("t5_data", g_inst[1].bus.AXI4_DATA, 64'hDEAD_BEEF_CAFE_F00D);
    chk("t5_one_done", 64'(g_inst[1].ndone - b1), 64'd1);
`ifndef RAND_LATENCY_EN
    chk("t5_lat0", 64'(g_inst[1].lat), 64'd0);
`endif

    b2 = g_inst[2].ndone;
    fetch(BASE, 2, 0);
    chk("t6_abort", 64'(g_inst[2].ndone - b2), 64'd0);
    fetch(BASE + 64'h10, 16, 0);
    chk("t6_data", g_inst[2].bus.AXI4_DATA, 64'h1111_2222_3333_4444);
    chk("t6_one_done", 64'(g_inst[2].ndone - b2), 64'd1);

    // Reset while the slower instances are still waiting.
    b2 = g_inst[2].ndone;
    @(posedge clk); #1 req = 1; addr = BASE + 64'd8;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0; req = 0;
    @(negedge clk);
    chk("t7_busy", 64'(busy_v), 64'd0);
    chk("t7_data", g_inst[2].bus.AXI4_DATA, 64'd0);
    chk("t7_err", 64'(g_inst[2].bus.resp_err), 64'd0);
    wait_idle();
    chk("t7_no_done", 64'(g_inst[2].ndone - b2), 64'd0);
    fetch(BASE + 64'h10, 16, 0);
    chk("t7_after", g_inst[0].bus.AXI4_DATA, 64'h1111_2222_3333_4444);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 5))
        0:       ra = BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 63));
        1:       ra = BASE - 64'($urandom_range(1, 64));
        default: ra = BASE + 64'($urandom_range(0, 63));
      endcase
      fetch(ra, $urandom_range(1, 16), 1);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/ifu_imem_responder.md
Name: ifu_imem_responder

Overview:
Memory-side responder for the instruction-fetch read handshake. It accepts a level-held read request with a 64-bit address from the fetch unit. After a programmable latency it returns the aligned 64-bit doubleword from an internal array, with a one-cycle done strobe. It then waits for the request to drop before accepting the next fetch. It serves as the instruction memory in simulation and as a bus-side model for the fetch path.

Parameters:
DEPTH, 1024, number of 64-bit words in the internal array; must be a power of 2.
BASE_ADDR, 64'h0000_0000_8000_0000, byte address that maps to word 0.
LATENCY, 2, wait cycles between request acceptance and response (0..255).
LFSR_SEED, 8'hA5, reset value of the latency LFSR; used only with RAND_LATENCY_EN; must be nonzero.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
Send_Signal  in  1  read request from the fetch unit; held high until that side completes.
AXI4_ADDR  in  64  fetch byte address; sampled only when the request is accepted.
AXI_READ_DONE  out  1  one-cycle response strobe.
AXI4_DATA  out  64  response data; stable from the done cycle until the next done.
resp_err  out  1  valid with done; 1 = address out of range.
ld_en  in  1  backdoor array write enable.
ld_idx  in  log2(DEPTH)  backdoor word index.
ld_data  in  64  backdoor write data.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; AXI_READ_DONE=0; AXI4_DATA=0; resp_err=0; busy=0; counter=0. Array contents are not reset. rst mid-operation aborts any pending response, and no done is issued.
- Address map: off = AXI4_ADDR - BASE_ADDR (64-bit, wraps mod 2^64). The address is in range iff off < DEPTH*8. idx = off[log2(DEPTH)+2:3]. Bits [2:0] are ignored, so the whole aligned doubleword is returned.
- States:
  - IDLE: when Send_Signal=1, latch idx and the range flag, load counter=LATENCY, set busy. Go to RESP if LATENCY=0, else WAIT.
  - WAIT: counter decrements by 1 each cycle. When counter==1 → RESP. If Send_Signal=0 in any WAIT cycle → IDLE with no response (abort).
  - RESP: lasts exactly one cycle. AXI_READ_DONE=1. AXI4_DATA = in range ? mem[idx] : 64'h0. resp_err = !in range. Always → DRAIN.
  - DRAIN: done=0. Stay until Send_Signal=0, then → IDLE. A request that stays high never causes a second response.
- Latency: if the request is first sampled high in IDLE at edge N, done is high during the cycle after edge N+LATENCY+1. Outputs are registered and there is no combinational input→output path.
- Data/err hold: they update only on entry to RESP and hold otherwise, including through IDLE.
- Array read happens on the cycle of entry to RESP.
- Backdoor load:
  - Writes mem[ld_idx] <= ld_data on any cycle, in any state, including during rst.
  - If the write hits the index being read on the same cycle, the read returns the old data.
- Minimum back-to-back spacing: at least one IDLE cycle with Send_Signal=0 between responses.

Optional Feature:
RAND_LATENCY_EN:
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) resets to LFSR_SEED and advances once per accepted request. The loaded counter is LATENCY + lfsr[2:0], where lfsr is the pre-advance value. This gives latencies of LATENCY to LATENCY+7; LATENCY+lfsr[2:0]=0 still goes directly to RESP.
- Undefined: no LFSR logic; latency is fixed at LATENCY.

Test Plan:
- LATENCY=2, load mem[0]=64'h0000_0013_0000_0093; hold Send_Signal with addr 0x8000_0000 → done one cycle at 3 cycles after accept, data=64'h0000_0013_0000_0093, resp_err=0; hold Send_Signal 5 more cycles → no second done.
- Addr 0x8000_0004 → same doubleword as 0x8000_0000; addr 0x8000_2000 (DEPTH=1024) → done, data=0, resp_err=1; addr 0x7FFF_FFF8 → resp_err=1.
- LATENCY=0, addr 0x8000_0008, mem[1]=64'hDEAD_BEEF_CAFE_F00D → done on the cycle after accept with that data.
- LATENCY=4, drop Send_Signal after 2 cycles → no done, return to IDLE; new request at 0x8000_0010 → normal response of mem[2].
- Assert rst during WAIT → no done, busy=0 on the next cycle, outputs zero; the following request works normally.
- RAND_LATENCY_EN, LATENCY=1, seed 8'hA5 → the first request's latency is 1+5=6 cycles; 20 requests all fall within 1..8 cycles and their order matches the LFSR reference model.
